m9k_tensor_reader: RTL and testbench
====================================

Name: m9k_tensor_reader

Overview:
- Read-side initiator for the single-port M9K scratch memory (15-bit word address, 32-bit data, one-cycle registered read).
- On start, it fetches a two-word tensor header at base_addr: word0 is the tag and word1 is the element count N.
- It then streams the N element words from base_addr+2 onward over a valid/ready interface to the compute datapath.
- It never writes memory.

Parameters:
- ADDR_W, 15, memory word-address width
- DATA_W, 32, memory word width
- MAX_LEN, 32766, largest legal N; a larger N is flagged as an error

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  ADDR_W  header address; captured when start is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the transfer finishes or is aborted on error
- err  output  1  one-cycle pulse coincident with done when the header is illegal
- tag  output  DATA_W  header word0; held from capture until the next accepted start
- len  output  DATA_W  header word1; same hold rule as tag
- mem_w_en  output  1  tied to 0
- mem_addr  output  ADDR_W  registered read address
- mem_data_store  output  DATA_W  tied to 0
- mem_data_load  input  DATA_W  read data; valid one cycle after the address
- out_valid  output  1  element available
- out_ready  input  1  consumer accepts the element
- out_data  output  DATA_W  element word
- out_last  output  1  high with the final element of the tensor

Behaviour:
- Reset:
  - rst=1 at a clock edge forces state IDLE.
  - All outputs go to 0, including tag, len, mem_addr, out_data.
  - The FIFO, issue counter and in-flight flag are cleared.
  - Reset mid-transfer abandons the transfer: no done, no err, pending elements discarded.
- Memory timing: mem_addr presented in cycle t yields mem_data_load in cycle t+1. mem_w_en=0 at all times.
- FSM states: IDLE, HDR0, HDR1, HDRW, STREAM, FIN.
  - IDLE: start=1 captures base_addr, then goes to HDR0.
  - HDR0: mem_addr=base. Go to HDR1.
  - HDR1: mem_addr=base+1. Capture mem_data_load into tag. Go to HDRW.
  - HDRW: capture mem_data_load into len, then check it:
    - If N>MAX_LEN, or base+1+N > 2^ADDR_W-1 (computed at ADDR_W+1 bits or wider, no wrap), go to FIN with error.
    - Else if N==0, go to FIN.
    - Else go to STREAM.
  - STREAM: issue element reads at addresses base+2 .. base+1+N in order. When the element with out_last is accepted (out_valid&&out_ready), go to FIN.
  - FIN: done=1 for this one cycle, err=1 if an error was flagged. Go to IDLE.
- Timing: start accepted at edge 0 puts HDR0 in cycle 1, the first element address in cycle 4 (in STREAM), and the first out_valid in cycle 6.
- Buffering:
  - 2-entry output FIFO; out_data/out_valid/out_last come from the head entry.
  - A returning read word is written to the FIFO in the cycle after its address.
  - Issue rule in a STREAM cycle: issue when issued<N and (fifo_count + inflight − pop) ≤ 1, where pop = out_valid&&out_ready this cycle. This guarantees the FIFO never overflows.
  - With out_ready held high, the stream sustains one element per cycle.
  - out_valid, out_data and out_last hold steady while out_ready=0.
- out_last: high when the head entry is element index N−1, counting from index 0.
- Ignored inputs: start is ignored when not IDLE, and start in the same cycle as rst is ignored.
- Registers: issued and popped counters are ADDR_W+1 bits; an address never wraps past 2^ADDR_W−1.

Test Plan:
1. Memory holds 1,10,1..10 at 0..11; base=0, start, out_ready=1.
   - tag=1, len=10.
   - Elements 1..10 on consecutive cycles 6..15; out_last with element 10.
   - done in cycle 16, err=0.
2. Same setup, out_ready toggled 1,0,1,0 then held 0 for 5 cycles.
   - Every element is delivered exactly once, in order.
   - out_data is stable while stalled.
   - mem_addr never runs more than 2 ahead of the accepted elements.
3. Header len=0 at base=100.
   - No out_valid.
   - done in cycle 4 after start, err=0.
4. base=32760 with len=10: address overflow.
   - done and err in the same cycle, no out_valid.
   - Repeat with len=32767 (>MAX_LEN) → same result.
5. rst pulsed while 4 elements are still pending.
   - All outputs are 0 the next cycle, no done.
   - A new start then runs a clean transfer.
6. start held high during a transfer: no restart, busy stays 1; done pulses once.

Source files
------------

// File: rtl/m9k_tensor_reader.sv
// Read-only initiator for the M9K scratch memory: fetches a {tag, length} header and streams the
// tensor elements that follow it over a valid/ready port through a 2-entry skid FIFO.
module m9k_tensor_reader #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_LEN = 32766
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] tag,
    output logic [DATA_W-1:0] len,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_store,
    input  logic [DATA_W-1:0] mem_data_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR0   = 3'd1;
    localparam logic [2:0] HDR1   = 3'd2;
    localparam logic [2:0] HDRW   = 3'd3;
    localparam logic [2:0] STREAM = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned XW = DATA_W + 1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic              err_q, err_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     popped_q, popped_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [CW-1:0] n_w;
    logic [XW-1:0] hdr_end;
    logic          hdr_bad;
    logic [2:0]    occ;
    logic          push, pop, issue, head_last;

    always_comb begin
        n_w       = len_q[CW-1:0];
        push      = inflight_q;
        pop       = (count_q != 2'd0) && out_ready;
        head_last = (popped_q + CW'(1)) == n_w;
        occ       = {1'b0, count_q} + {2'b00, inflight_q};
        // Reserve a FIFO slot for every outstanding read so a returning word always fits.
        issue     = (state_q == STREAM) && (issued_q < n_w) && (occ <= (3'd1 + {2'b00, pop}));
        // Header end address evaluated one bit wider than the data so it cannot wrap.
        hdr_end   = XW'(base_q) + XW'(1) + XW'(mem_data_load);
        hdr_bad   = (mem_data_load > DATA_W'(MAX_LEN)) ||
                    (hdr_end > XW'((64'd1 << ADDR_W) - 64'd1));

        state_d    = state_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        tag_d      = tag_q;
        len_d      = len_q;
        err_d      = err_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        inflight_d = issue;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    mem_addr_d = base_addr;
                    err_d      = 1'b0;
                    issued_d   = '0;
                    popped_d   = '0;
                    state_d    = HDR0;
                end
            end
            HDR0: begin
                mem_addr_d = base_q + ADDR_W'(1);
                state_d    = HDR1;
            end
            HDR1: begin
                tag_d   = mem_data_load;
                state_d = HDRW;
            end
            HDRW: begin
                len_d = mem_data_load;
                if (hdr_bad) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (mem_data_load == '0) begin
                    state_d = FIN;
                end else begin
                    mem_addr_d = base_q + ADDR_W'(2);
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (issue) begin
                    issued_d = issued_q + CW'(1);
                    // mem_addr always shows the next element; stop at the last one so it never wraps.
                    if ((issued_q + CW'(1)) < n_w) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
                if (pop && head_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = mem_data_load;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            popped_d = popped_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            tag_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            tag_q      <= tag_d;
            len_q      <= len_d;
            err_q      <= err_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        busy           = state_q != IDLE;
        done           = state_q == FIN;
        err            = (state_q == FIN) && err_q;
        tag            = tag_q;
        len            = len_q;
        mem_w_en       = 1'b0;
        mem_addr       = mem_addr_q;
        mem_data_store = '0;
        out_valid      = count_q != 2'd0;
        out_data       = out_valid ? fifo_q[rd_ptr_q] : '0;
        out_last       = out_valid && head_last;
    end

endmodule

// File: tb/tb_m9k_tensor_reader.sv
// Bench for m9k_tensor_reader: a table of header/stream transfers with a behavioural M9K model
// and an element scoreboard, plus reset and held-start sequences folded into the table.
module tb_m9k_tensor_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] tag;
    logic [31:0] len;
    logic        mem_w_en;
    logic [14:0] mem_addr;
    logic [31:0] mem_data_store;
    logic [31:0] mem_data_load;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    m9k_tensor_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .tag           (tag),
        .len           (len),
        .mem_w_en      (mem_w_en),
        .mem_addr      (mem_addr),
        .mem_data_store(mem_data_store),
        .mem_data_load (mem_data_load),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [32768];
    always @(posedge clk) mem_data_load <= mem[mem_addr];

    typedef struct {
        logic [14:0] base;
        logic [31:0] tag;
        logic [31:0] len;
        int          mode;       // 0 ready high, 1 scripted stalls, 2 random ready
        int          hold_start;
        int          exp_err;
        int          exp_done;   // done cycle after start edge, -1 = not checked
        int          rst_after;  // pulse rst after this many accepts, -1 = never
        int          ramp;       // elements are 1..N instead of random
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " done"}, 32'(done), 32'd0);
        chk({name, " err"}, 32'(err), 32'd0);
        chk({name, " tag"}, tag, 32'd0);
        chk({name, " len"}, len, 32'd0);
        chk({name, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({name, " mem_w_en"}, 32'(mem_w_en), 32'd0);
        chk({name, " mem_data_store"}, mem_data_store, 32'd0);
        chk({name, " out_valid"}, 32'(out_valid), 32'd0);
        chk({name, " out_data"}, out_data, 32'd0);
        chk({name, " out_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          acc;
        int          off;
        bit          got_done;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [31:0] d;
        string       nm;
        nm = $sformatf("v%0d", idx);
        mem[int'(v.base)] = v.tag;
        mem[int'(v.base) + 1] = v.len;
        exp_q.delete();
        if (v.exp_err == 0) begin
            for (int i = 0; i < int'(v.len); i++) begin
                d = (v.ramp != 0) ? 32'(i + 1) : $urandom;
                mem[int'(v.base) + 2 + i] = d;
                exp_q.push_back(d);
            end
        end
        @(negedge clk);
        start = 1'b1;
        base_addr = v.base;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (v.hold_start == 0) start = 1'b0;
        acc = 0;
        got_done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
            case (v.mode)
                1: begin
                    if (cyc < 6) out_ready = 1'b1;
                    else if (cyc - 6 < 4) out_ready = ((cyc - 6) % 2) == 0;
                    else if (cyc - 6 < 9) out_ready = 1'b0;
                    else out_ready = 1'b1;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (prev_stall) begin
                chk({nm, " stall valid"}, 32'(out_valid), 32'd1);
                chk({nm, " stall data"}, out_data, prev_data);
            end
            chk({nm, " busy"}, 32'(busy), 32'd1);
            off = int'(mem_addr) - int'(v.base) - 2;
            chk({nm, " addr run-ahead"}, 32'(off <= acc + 2), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({nm, " unexpected element"}, 32'(out_valid), 32'd0);
                end else begin
                    chk({nm, " data"}, out_data, exp_q[0]);
                    chk({nm, " last"}, 32'(out_last), 32'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                end
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                got_done = 1'b1;
                start = 1'b0;
                chk({nm, " err"}, 32'(err), 32'(v.exp_err));
                if (v.exp_done > 0) chk({nm, " done cycle"}, 32'(cyc), 32'(v.exp_done));
                chk({nm, " remaining"}, 32'(exp_q.size()), 32'd0);
                chk({nm, " tag"}, tag, v.tag);
                chk({nm, " len"}, len, v.len);
            end
            if (v.rst_after >= 0 && acc == v.rst_after) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                chk_zero({nm, " after rst"});
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk({nm, " no done after rst"}, 32'(done), 32'd0);
                end
                exp_q.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
        if (!got_done) chk({nm, " done timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
        chk({nm, " single done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{15'd0,     32'd1, 32'd10,    0, 0, 0, 16, -1, 1};
        vecs[1]  = '{15'd0,     32'd1, 32'd10,    1, 0, 0, -1, -1, 1};
        vecs[2]  = '{15'd100,   32'd7, 32'd0,     0, 0, 0, 4,  -1, 0};
        vecs[3]  = '{15'd32760, 32'd5, 32'd10,    0, 0, 1, 4,  -1, 0};
        vecs[4]  = '{15'd32760, 32'd5, 32'd32767, 0, 0, 1, 4,  -1, 0};
        vecs[5]  = '{15'd1,     32'd9, 32'd32766, 0, 0, 1, 4,  -1, 0};
        vecs[6]  = '{15'd32757, 32'd3, 32'd9,     0, 0, 0, 15, -1, 0};
        vecs[7]  = '{15'd400,   32'd2, 32'd1,     0, 0, 0, 7,  -1, 0};
        vecs[8]  = '{15'd200,   32'd4, 32'd3,     2, 0, 0, -1, -1, 0};
        vecs[9]  = '{15'd300,   32'd6, 32'd5,     0, 1, 0, 11, -1, 0};
        vecs[10] = '{15'd0,     32'd1, 32'd10,    0, 0, 0, -1, 6,  1};
        vecs[11] = '{15'd0,     32'd1, 32'd10,    0, 0, 0, 16, -1, 1};

        for (int i = 0; i < 32768; i++) mem[i] = '0;
        rst = 1'b1;
        start = 1'b1;
        base_addr = 15'd5;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start with rst ignored", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
